// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the instruction memory.
// Packs bytes MSB first into B-bit words and writes them from address 0 until halt or full.
module instr_mem_loader #(
  parameter int             B         = 16,
  parameter int             W         = 11,
  parameter logic [B-1:0]   HALT_WORD = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_done_tick,
  output logic         mem_wr_en,
  output logic [W-1:0] mem_addr,
  output logic [B-1:0] mem_w_data,
  output logic         busy,
  output logic         done,
  output logic         full,
  output logic [W:0]   word_count
);

  localparam int NB = B / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);
  localparam logic [W-1:0]  A_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0] k;
  logic [B-1:0]  acc;
  logic [B-1:0]  word_nx;
  logic [W-1:0]  addr;

  logic wr_halt;
  logic wr_last;
  logic wr_term;
  logic accept;
  logic last_byte;
  logic arm;

  assign wr_halt   = mem_wr_en && (mem_w_data == HALT_WORD);
  assign wr_last   = mem_wr_en && (mem_addr == A_MAX);
  assign wr_term   = wr_halt || wr_last;
  // a byte arriving during the final write belongs to no load
  assign accept    = (state == RECV) && rx_done_tick && !wr_term;
  assign last_byte = accept && (k == K_LAST);
  assign arm       = start && (state != RECV);

  always_comb begin
    word_nx = acc;
    for (int i = 0; i < NB; i++) begin
      if (k == KW'(i)) begin
        word_nx[B-1-8*i -: 8] = rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RECV;
      RECV: if (wr_term) state_nx = DONE;
      DONE: if (start) state_nx = RECV;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECV);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k          <= '0;
      acc        <= '0;
      addr       <= '0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_w_data <= '0;
      word_count <= '0;
      full       <= 1'b0;
    end else begin
      mem_wr_en <= last_byte;
      if (arm) begin
        k          <= '0;
        acc        <= '0;
        addr       <= '0;
        word_count <= '0;
        full       <= 1'b0;
      end else begin
        if (accept) begin
          acc <= word_nx;
          k   <= last_byte ? '0 : k + 1'b1;
        end
        // word completing in a write cycle takes the address after it
        if (last_byte) begin
          mem_w_data <= word_nx;
          mem_addr   <= mem_wr_en ? addr + 1'b1 : addr;
        end
        if (mem_wr_en) begin
          word_count <= word_count + 1'b1;
          full       <= wr_last && !wr_halt;
          if (!wr_term) begin
            addr <= addr + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: vector tables plus scoreboard
// of expected memory writes checked by a negedge monitor.
module tb_instr_mem_loader;

  localparam int B = 16;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_done_tick = 1'b0;
  logic         mem_wr_en;
  logic [W-1:0] mem_addr;
  logic [B-1:0] mem_w_data;
  logic         busy;
  logic         done;
  logic         full;
  logic [W:0]   word_count;

  instr_mem_loader #(.B(B), .W(W), .HALT_WORD(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_w_data   (mem_w_data),
    .busy         (busy),
    .done         (done),
    .full         (full),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] addr;
    logic [B-1:0] data;
  } exp_t;

  typedef struct {
    logic [B-1:0] word;
    logic [W-1:0] addr;
    bit           gap;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_wr_en) begin
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_w_data), 32'(e.data));
      end
      chk("wr_pulse_width", 32'(prev_wr), 32'd0);
    end
    prev_wr = mem_wr_en;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [B-1:0] w, input logic [W-1:0] a,
                           input bit gap);
    sb.push_back('{addr: a, data: w});
    tick(w[15:8]);
    if (gap) idle(1);
    tick(w[7:0]);
    if (gap) idle(1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    vec_t t1[3];
    vec_t t2[3];
    vec_t t3[5];
    t1[0] = '{16'h1234, 11'd0, 1'b1};
    t1[1] = '{16'h5678, 11'd1, 1'b1};
    t1[2] = '{16'h0000, 11'd2, 1'b1};
    t2[0] = '{16'hBEEF, 11'd0, 1'b0};
    t2[1] = '{16'hCAFE, 11'd1, 1'b0};
    t2[2] = '{16'h0102, 11'd2, 1'b0};
    t3[0] = '{16'h1111, 11'd0, 1'b1};
    t3[1] = '{16'h2222, 11'd1, 1'b1};
    t3[2] = '{16'h3333, 11'd2, 1'b1};
    t3[3] = '{16'h4444, 11'd3, 1'b0};
    t3[4] = '{16'h0000, 11'd4, 1'b0};

    idle(3);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_w_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    reset = 1'b1;
    idle(2);

    tick(8'h12);
    tick(8'h34);
    idle(3);
    chk("pre_busy", 32'(busy), 32'd0);
    chk("pre_wc", 32'(word_count), 32'd0);
    chk("pre_addr", 32'(mem_addr), 32'd0);

    pulse_start();
    chk("arm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) send_word(t1[i].word, t1[i].addr, t1[i].gap);
    wait_done(20);
    chk("t1_full", 32'(full), 32'd0);
    chk("t1_wc", 32'(word_count), 32'd3);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    tick(8'hFF);
    tick(8'hEE);
    idle(3);
    chk("post_done", 32'(done), 32'd1);
    chk("post_wc", 32'(word_count), 32'd3);
    chk("post_addr", 32'(mem_addr), 32'd2);
    chk("post_data", 32'(mem_w_data), 32'd0);

    pulse_start();
    for (int i = 0; i < 3; i++) send_word(t2[i].word, t2[i].addr, t2[i].gap);
    sb.push_back('{addr: 11'd3, data: 16'h0000});
    tick(8'h00);
    tick(8'h00);
    chk("lat_wr_en", 32'(mem_wr_en), 32'd1);
    chk("lat_done_early", 32'(done), 32'd0);
    idle(1);
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_wr_off", 32'(mem_wr_en), 32'd0);
    chk("b2b_wc", 32'(word_count), 32'd4);
    chk("b2b_full", 32'(full), 32'd0);

    pulse_start();
    for (int i = 0; i < 3; i++) send_word(t3[i].word, t3[i].addr, t3[i].gap);
    pulse_start();
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 3; i < 5; i++) send_word(t3[i].word, t3[i].addr, t3[i].gap);
    wait_done(20);
    chk("restart_wc", 32'(word_count), 32'd5);

    pulse_start();
    tick(8'hAB);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_data", 32'(mem_w_data), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    pulse_start();
    send_word(16'h0000, 11'd0, 1'b0);
    wait_done(20);
    chk("mid_rst_wc2", 32'(word_count), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);

    pulse_start();
    for (int i = 0; i < 2048; i++) send_word(16'hA5A5, W'(i), 1'b0);
    idle(3);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_done", 32'(done), 32'd1);
    chk("full_wc", 32'(word_count), 32'd2048);
    chk("full_addr", 32'(mem_addr), 32'h7FF);
    tick(8'hA5);
    tick(8'hA5);
    idle(3);
    chk("full_wc_after", 32'(word_count), 32'd2048);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
